// File: rtl/err_code_vote_if.sv
// Sample bus between the division datapath and the error-code voter, plus the fault outputs.
// Purely wiring; no storage or latency of its own.
// No backpressure: a sample is accepted on every cycle division_o_tvalid is high.
interface err_code_vote_if #(
   parameter int DATA_W = 32,
   parameter int N_CH   = 8,
   parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
   parameter int CNT_W  = 8
);
   logic [DATA_W-1:0] division_o;
   logic              division_o_tvalid;
   logic              clear_i;
   logic [N_CH:0]     judge_result;
   logic              judge_result_en;
   logic [N_CH-1:0]   fault_flags;
   logic              fault_new;
   logic [CH_W-1:0]   fault_ch;
   logic [CNT_W-1:0]  invalid_cnt;

   // Datapath / fault controller side
   modport master (
      output division_o, division_o_tvalid, clear_i,
      input  judge_result, judge_result_en, fault_flags, fault_new, fault_ch, invalid_cnt
   );

   // Voter side
   modport slave (
      input  division_o, division_o_tvalid, clear_i,
      output judge_result, judge_result_en, fault_flags, fault_new, fault_ch, invalid_cnt
   );
endinterface

// File: rtl/err_code_vote.sv
// Decodes the error-code field of each division result and confirms faults over consecutive samples.
// Latency: one cycle, all outputs registered on the edge that samples tvalid.
// No backpressure: one sample per valid cycle is always accepted.
module err_code_vote #(
   parameter int DATA_W       = 32,
   parameter int FIELD_MSB    = 30,
   parameter int FIELD_LSB    = 7,
   parameter int N_CH         = 8,
   parameter int CODES_PER_CH = 2,
   parameter int CONFIRM_CNT  = 3,
   parameter int CNT_W        = 8,
   parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic          clk,
   input  logic          rstn,
   err_code_vote_if.slave bus
);
   localparam int FW   = FIELD_MSB - FIELD_LSB + 1;
   localparam int ST_W = (CONFIRM_CNT > 1) ? $clog2(CONFIRM_CNT + 1) : 1;

   logic [FW-1:0]    code;
   logic             code_inv;
   logic [CH_W-1:0]  dec_ch;

   logic [N_CH:0]    jr_q, jr_d;
   logic             jr_en_q, jr_en_d;
   logic [N_CH-1:0]  flags_q, flags_d;
   logic             fault_new_q, fault_new_d;
   logic [CH_W-1:0]  fault_ch_q, fault_ch_d;
   logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
   logic [ST_W-1:0]  streak_q, streak_d;
   logic [CH_W-1:0]  last_ch_q, last_ch_d;

   // Only the code field is decoded; the rest of the word is intentionally ignored.
   logic unused_div;
   assign unused_div = ^bus.division_o;

   // Decode the code field into a channel by range comparison, so no divider is built.
   always_comb begin
      code     = bus.division_o[FIELD_MSB:FIELD_LSB];
      code_inv = 1'b1;
      dec_ch   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if ((64'(code) > 64'(i * CODES_PER_CH)) &&
             (64'(code) <= 64'((i + 1) * CODES_PER_CH))) begin
            code_inv = 1'b0;
            dec_ch   = CH_W'(i);
         end
      end
   end

   // Next-state: judge result, streak filter, fault latch and invalid counter; clear wins over everything.
   always_comb begin
      jr_d        = jr_q;
      jr_en_d     = bus.division_o_tvalid;
      flags_d     = flags_q;
      fault_new_d = 1'b0;
      fault_ch_d  = fault_ch_q;
      inv_cnt_d   = inv_cnt_q;
      streak_d    = streak_q;
      last_ch_d   = last_ch_q;

      if (bus.division_o_tvalid) begin
         jr_d               = '0;
         jr_d[N_CH]         = code_inv;
         jr_d[N_CH-1:0]     = code_inv ? '0 : (N_CH'(1) << dec_ch);

         if (!bus.clear_i) begin
            if (code_inv) begin
               streak_d = '0;
               if (inv_cnt_q != '1) inv_cnt_d = inv_cnt_q + CNT_W'(1);
            end else if ((dec_ch == last_ch_q) && (streak_q != '0)) begin
               // Streak saturates at the confirm count so a held fault cannot re-trigger.
               if (streak_q < ST_W'(CONFIRM_CNT)) streak_d = streak_q + ST_W'(1);
            end else begin
               streak_d  = ST_W'(1);
               last_ch_d = dec_ch;
            end

            if (!code_inv && (streak_d == ST_W'(CONFIRM_CNT)) && !flags_q[dec_ch]) begin
               flags_d[dec_ch] = 1'b1;
               fault_new_d     = 1'b1;
               fault_ch_d      = dec_ch;
            end
         end
      end

      // fault_ch deliberately survives a clear so the controller can still read the last culprit.
      if (bus.clear_i) begin
         flags_d     = '0;
         inv_cnt_d   = '0;
         streak_d    = '0;
         fault_new_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         jr_q        <= '0;
         jr_en_q     <= 1'b0;
         flags_q     <= '0;
         fault_new_q <= 1'b0;
         fault_ch_q  <= '0;
         inv_cnt_q   <= '0;
         streak_q    <= '0;
         last_ch_q   <= '0;
      end else begin
         jr_q        <= jr_d;
         jr_en_q     <= jr_en_d;
         flags_q     <= flags_d;
         fault_new_q <= fault_new_d;
         fault_ch_q  <= fault_ch_d;
         inv_cnt_q   <= inv_cnt_d;
         streak_q    <= streak_d;
         last_ch_q   <= last_ch_d;
      end
   end

   assign bus.judge_result    = jr_q;
   assign bus.judge_result_en = jr_en_q;
   assign bus.fault_flags     = flags_q;
   assign bus.fault_new       = fault_new_q;
   assign bus.fault_ch        = fault_ch_q;
   assign bus.invalid_cnt     = inv_cnt_q;
endmodule

// File: tb/tb_err_code_vote.sv
// Self-checking bench for err_code_vote: vector table feeding a scoreboard, plus reset and saturation sequences.
// Expected outputs are checked one cycle after each sample is driven.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_err_code_vote;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   err_code_vote_if #(.DATA_W(32), .N_CH(8), .CH_W(3), .CNT_W(8)) bus ();
   err_code_vote_if #(.DATA_W(32), .N_CH(8), .CH_W(3), .CNT_W(2)) bus2 ();

   err_code_vote #(.DATA_W(32), .FIELD_MSB(30), .FIELD_LSB(7), .N_CH(8), .CODES_PER_CH(2),
                   .CONFIRM_CNT(3), .CNT_W(8), .CH_W(3))
      dut (.clk(clk), .rstn(rstn), .bus(bus));

   err_code_vote #(.DATA_W(32), .FIELD_MSB(30), .FIELD_LSB(7), .N_CH(8), .CODES_PER_CH(2),
                   .CONFIRM_CNT(3), .CNT_W(2), .CH_W(3))
      dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

   typedef struct {
      bit          vld;
      bit          clr;
      int          code;
      int          idle;
      logic [8:0]  jr;
      logic [7:0]  flags;
      logic        fnew;
      logic [2:0]  fch;
      logic [7:0]  inv;
      string       tag;
   } vec_t;

   typedef struct {
      logic [8:0]  jr;
      logic [7:0]  flags;
      logic        fnew;
      logic [2:0]  fch;
      logic [7:0]  inv;
      string       tag;
   } exp_t;

   vec_t       vecs[$];
   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [8:0] last_jr = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endtask

   task automatic add(input bit vld, input bit clr, input int code, input int idle,
                      input logic [8:0] jr, input logic [7:0] flags, input logic fnew,
                      input logic [2:0] fch, input logic [7:0] inv, input string tag);
      vec_t v;
      v.vld = vld; v.clr = clr; v.code = code; v.idle = idle;
      v.jr = jr; v.flags = flags; v.fnew = fnew; v.fch = fch; v.inv = inv; v.tag = tag;
      vecs.push_back(v);
   endtask

   // Called just after a falling edge: drive one cycle, then leave idle cycles.
   task automatic apply(input vec_t v);
      exp_t e;
      bus.division_o        = 32'(v.code) << 7;
      bus.division_o_tvalid = v.vld;
      bus.clear_i           = v.clr;
      if (v.vld) begin
         e.jr = v.jr; e.flags = v.flags; e.fnew = v.fnew; e.fch = v.fch; e.inv = v.inv; e.tag = v.tag;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.division_o_tvalid = 1'b0;
      bus.clear_i           = 1'b0;
      repeat (v.idle) @(negedge clk);
   endtask

   // Monitor: every judge_result_en cycle retires one scoreboard entry; idle cycles must be quiet.
   always @(negedge clk) begin
      if (!rstn) begin
         last_jr = '0;
      end else if (bus.judge_result_en) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_en: got judge_result_en=1 expected no pending sample");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_judge"},   32'(bus.judge_result), 32'(e.jr));
            chk({e.tag, "_flags"},   32'(bus.fault_flags),  32'(e.flags));
            chk({e.tag, "_new"},     32'(bus.fault_new),    32'(e.fnew));
            chk({e.tag, "_ch"},      32'(bus.fault_ch),     32'(e.fch));
            chk({e.tag, "_inv"},     32'(bus.invalid_cnt),  32'(e.inv));
            last_jr = e.jr;
         end
      end else begin
         chk("idle_fault_new", 32'(bus.fault_new), 32'd0);
         chk("idle_judge_hold", 32'(bus.judge_result), 32'(last_jr));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.division_o = '0;  bus.division_o_tvalid = 1'b0;  bus.clear_i = 1'b0;
      bus2.division_o = '0; bus2.division_o_tvalid = 1'b0; bus2.clear_i = 1'b0;

      // 1: defaults and first sample
      add(1,0, 3,2, 9'h002, 8'h00,0,3'd0,8'd0, "t1_code3");
      // 2: same channel across idle gaps, then no repeat pulse
      add(1,0, 5,1, 9'h004, 8'h00,0,3'd0,8'd0, "t2_s1");
      add(1,0, 6,1, 9'h004, 8'h00,0,3'd0,8'd0, "t2_s2");
      add(1,0, 5,1, 9'h004, 8'h04,1,3'd2,8'd0, "t2_latch");
      add(1,0, 5,1, 9'h004, 8'h04,0,3'd2,8'd0, "t2_norepeat");
      add(0,1, 0,1, 9'h000, 8'h00,0,3'd0,8'd0, "clr");
      // 3: streak broken by another channel
      add(1,0, 5,1, 9'h004, 8'h00,0,3'd2,8'd0, "t3_a");
      add(1,0, 5,1, 9'h004, 8'h00,0,3'd2,8'd0, "t3_b");
      add(1,0, 7,1, 9'h008, 8'h00,0,3'd2,8'd0, "t3_break");
      add(1,0, 5,1, 9'h004, 8'h00,0,3'd2,8'd0, "t3_restart");
      add(1,0, 5,1, 9'h004, 8'h00,0,3'd2,8'd0, "t3_s2");
      add(1,0, 5,1, 9'h004, 8'h04,1,3'd2,8'd0, "t3_latch");
      add(0,1, 0,1, 9'h000, 8'h00,0,3'd0,8'd0, "clr");
      // 4: invalid codes (zero and above range) reset the streak
      add(1,0, 0,1, 9'h100, 8'h00,0,3'd2,8'd1, "t4_code0");
      add(1,0,17,1, 9'h100, 8'h00,0,3'd2,8'd2, "t4_code17");
      add(1,0, 1,1, 9'h001, 8'h00,0,3'd2,8'd2, "t4_c1a");
      add(1,0, 1,1, 9'h001, 8'h00,0,3'd2,8'd2, "t4_c1b");
      add(1,0, 0,1, 9'h100, 8'h00,0,3'd2,8'd3, "t4_inv");
      add(1,0, 1,1, 9'h001, 8'h00,0,3'd2,8'd3, "t4_nolatch");
      add(0,1, 0,1, 9'h000, 8'h00,0,3'd0,8'd0, "clr");
      // 5: set flags 05, clear coincident with a sample, then back-to-back latch on channel 7
      add(1,0, 1,1, 9'h001, 8'h00,0,3'd2,8'd0, "t5_c1a");
      add(1,0, 1,1, 9'h001, 8'h00,0,3'd2,8'd0, "t5_c1b");
      add(1,0, 1,1, 9'h001, 8'h01,1,3'd0,8'd0, "t5_ch0");
      add(1,0, 5,1, 9'h004, 8'h01,0,3'd0,8'd0, "t5_c5a");
      add(1,0, 5,1, 9'h004, 8'h01,0,3'd0,8'd0, "t5_c5b");
      add(1,0, 5,1, 9'h004, 8'h05,1,3'd2,8'd0, "t5_ch2");
      add(1,1,15,1, 9'h080, 8'h00,0,3'd2,8'd0, "t5_clr15");
      add(1,0,15,0, 9'h080, 8'h00,0,3'd2,8'd0, "t5_b2b1");
      add(1,0,15,0, 9'h080, 8'h00,0,3'd2,8'd0, "t5_b2b2");
      add(1,0,15,1, 9'h080, 8'h80,1,3'd7,8'd0, "t5_ch7");

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_judge",   32'(bus.judge_result),    32'd0);
      chk("reset_en",      32'(bus.judge_result_en), 32'd0);
      chk("reset_flags",   32'(bus.fault_flags),     32'd0);
      chk("reset_new",     32'(bus.fault_new),       32'd0);
      chk("reset_ch",      32'(bus.fault_ch),        32'd0);
      chk("reset_inv",     32'(bus.invalid_cnt),     32'd0);
      rstn = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) apply(vecs[i]);

      // 6a: reset asserted mid-streak discards the streak
      begin
         vec_t v;
         v.vld = 1; v.clr = 0; v.code = 9; v.idle = 0;
         v.jr = 9'h010; v.flags = 8'h80; v.fnew = 0; v.fch = 3'd7; v.inv = 8'd0; v.tag = "t6_c9a";
         apply(v);
         v.tag = "t6_c9b"; v.idle = 1;
         apply(v);
         rstn = 1'b0;
         #2;
         chk("midrst_judge", 32'(bus.judge_result),    32'd0);
         chk("midrst_en",    32'(bus.judge_result_en), 32'd0);
         chk("midrst_flags", 32'(bus.fault_flags),     32'd0);
         chk("midrst_new",   32'(bus.fault_new),       32'd0);
         chk("midrst_ch",    32'(bus.fault_ch),        32'd0);
         chk("midrst_inv",   32'(bus.invalid_cnt),     32'd0);
         @(negedge clk);
         rstn = 1'b1;
         @(negedge clk);
         v.jr = 9'h010; v.flags = 8'h00; v.fnew = 0; v.fch = 3'd0; v.inv = 8'd0;
         v.tag = "t6_after_rst"; v.idle = 2;
         apply(v);
      end

      // 6b: narrow invalid counter saturates
      bus2.division_o        = 32'h0;
      bus2.division_o_tvalid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("sat_inv_%0d", k), 32'(bus2.invalid_cnt), (k < 3) ? 32'(k) : 32'd3);
      end
      bus2.division_o_tvalid = 1'b0;
      @(negedge clk);
      chk("sat_judge_invalid", 32'(bus2.judge_result), 32'h100);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
